wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  MEM/WB pipeline stage: the write side of the register file. Registers MEM results.
//  Waits for data-memory read responses on loads, aligns and extends load data, and
//  drives we/waddr/wdata into the register file. Stalls the pipeline while a load is pending.
// PARAMETERS
//  LD_TIMEOUT   16   max cycles in WAIT_LD before abort (1..255)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   synchronous reset, active-low (`RstEna = 1'b0)
//  mem_valid      in   1   MEM stage presents an instruction this cycle
//  mem_wreg       in   1   instruction writes a GPR
//  mem_wd         in   5   destination register address
//  mem_wdata      in   32  ALU/move result (non-load)
//  mem_is_load    in   1   instruction is a load
//  mem_ld_op      in   3   0=LW 1=LB 2=LBU 3=LH 4=LHU (others = LW)
//  mem_addr_lo    in   2   load address bits [1:0]
//  dmem_rvalid    in   1   data memory read data valid (1-cycle pulse)
//  dmem_rdata     in   32  data memory read data, big-endian word
//  stall_i        in   1   hold stage (downstream/global stall)
//  flush_i        in   1   kill stage contents
//  wb_we          out  1   register file write enable
//  wb_waddr       out  5   register file write address
//  wb_wdata       out  32  register file write data
//  stall_req_o    out  1   request pipeline stall (load pending)
//  ld_err_o       out  1   sticky: load timed out
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE, wb_we=0, wb_waddr=0, wb_wdata=0, stall_req_o=0, ld_err_o=0, timer=0.
//  States: IDLE, WAIT_LD.
//  IDLE, mem_valid=1, mem_is_load=0: next cycle wb_we=mem_wreg, wb_waddr=mem_wd, wb_wdata=mem_wdata.
//  IDLE, mem_valid=1, mem_is_load=1: latch wd/op/addr_lo/wreg; ->WAIT_LD; wb_we=0 next cycle.
//  stall_req_o is combinational: 1 when (IDLE & mem_valid & mem_is_load) or WAIT_LD.
//  WAIT_LD: timer increments each cycle; on dmem_rvalid: wb_we=latched wreg, wb_waddr=latched wd,
//   wb_wdata=aligned data, ->IDLE, timer=0. stall_req_o drops in the cycle rvalid is seen.
//  dmem_rvalid in IDLE is ignored. rvalid in the same cycle the load is issued is ignored.
//  Timeout: timer==LD_TIMEOUT-1 without rvalid -> ->IDLE, wb_we=0, ld_err_o=1 (sticky until reset).
//  Alignment (big-endian): byte k = rdata[31-8k -: 8]; half at addr_lo[1]: 0 -> [31:16], 1 -> [15:0].
//   LB/LH sign-extend to 32; LBU/LHU zero-extend. LW ignores addr_lo.
//  mem_wd==0 with wreg=1: forwarded unchanged (regfile discards $0 writes).
//  Write pulse: wb_we is high for exactly one cycle per retiring instruction unless stall_i holds it.
//  stall_i=1: all registers hold (state, timer, outputs). Repeating a write of the same
//   addr/data is harmless. In WAIT_LD, rvalid during stall_i is still captured; data is held.
//  flush_i=1 (priority over stall_i and rvalid): wb_we=0, state=IDLE, timer=0; ld_err_o unchanged.
//  Reset mid-load: returns to IDLE; a late rvalid is ignored.
//  Latency: ALU result 1 cycle MEM->regfile; load = rvalid cycle + 1.
// CONFIGURATION
//  WB_LOAD_EXT_EN defined: full LB/LBU/LH/LHU alignment and extension as above.
//  Not defined: every load is treated as LW; mem_ld_op and mem_addr_lo are ignored;
//   wb_wdata = dmem_rdata unchanged.
// TESTING
//  Reset held 2 cycles -> all outputs 0. Release -> stall_req_o=0.
//  ALU op wd=5, data=32'h1234_5678 -> next cycle wb_we=1 for 1 cycle, waddr=5, wdata=32'h1234_5678.
//  LB, addr_lo=2, rvalid 3 cycles later, rdata=32'hAABB_CCDD -> stall_req_o high 4 cycles;
//   wdata=32'hFFFF_FFCC; LBU -> 32'h0000_00CC; LH addr_lo=0 -> 32'hFFFF_AABB.
//  Load with no rvalid, LD_TIMEOUT=16 -> at cycle 16 state IDLE, wb_we never 1, ld_err_o=1.
//  flush_i asserted in the same cycle as rvalid -> wb_we=0, state IDLE, next ALU op retires normally.
//  stall_i=1 for 3 cycles after an ALU write -> outputs held; release -> wb_we=0 next idle cycle.

Source files
------------

// File: rtl/wb_stage.sv
// MEM/WB stage: registers ALU results, waits for load data, aligns it and drives the register file write port.
// Optional feature: define WB_LOAD_EXT_EN for LB/LBU/LH/LHU alignment and extension; otherwise every load is LW.
module wb_stage #(
    parameter int unsigned LD_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_wreg,
    input  logic [4:0]  mem_wd,
    input  logic [31:0] mem_wdata,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_ld_op,
    input  logic [1:0]  mem_addr_lo,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        stall_req_o,
    output logic        ld_err_o
);

    typedef enum logic {IDLE = 1'b0, WAIT_LD = 1'b1} state_e;

    localparam logic [7:0] TMO_LAST = 8'(LD_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [4:0]  ld_wd_q, ld_wd_d;
    logic        ld_wreg_q, ld_wreg_d;
    logic        got_q, got_d;
    logic [31:0] got_data_q, got_data_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic        load_accept;
    logic [31:0] ld_raw;
    logic [31:0] ld_data;

    assign load_accept = (state_q == IDLE) && mem_valid && mem_is_load && !stall_i && !flush_i;
    // Data captured while stalled takes precedence over the live bus on release.
    assign ld_raw      = got_q ? got_data_q : dmem_rdata;

`ifdef WB_LOAD_EXT_EN
    logic [2:0]  ld_op_q;
    logic [1:0]  ld_lo_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_op_q <= 3'd0;
            ld_lo_q <= 2'd0;
        end else if (load_accept) begin
            ld_op_q <= mem_ld_op;
            ld_lo_q <= mem_addr_lo;
        end
    end

    // Big-endian lanes: byte 0 and the low half-address live in the upper bits.
    always_comb begin
        case (ld_lo_q)
            2'd0:    ld_byte = ld_raw[31:24];
            2'd1:    ld_byte = ld_raw[23:16];
            2'd2:    ld_byte = ld_raw[15:8];
            default: ld_byte = ld_raw[7:0];
        endcase
        ld_half = ld_lo_q[1] ? ld_raw[15:0] : ld_raw[31:16];
        case (ld_op_q)
            3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    ld_data = {24'd0, ld_byte};
            3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {16'd0, ld_half};
            default: ld_data = ld_raw;
        endcase
    end
`else
    logic unused_ld_cfg;
    assign unused_ld_cfg = ^{mem_ld_op, mem_addr_lo};
    assign ld_data       = ld_raw;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        timer_d    = timer_q;
        ld_wd_d    = ld_wd_q;
        ld_wreg_d  = ld_wreg_q;
        got_d      = got_q;
        got_data_d = got_data_q;
        we_d       = we_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;

        if (flush_i) begin
            state_d = IDLE;
            timer_d = 8'd0;
            got_d   = 1'b0;
            we_d    = 1'b0;
        end else if (stall_i) begin
            if (state_q == WAIT_LD && dmem_rvalid && !got_q) begin
                got_d      = 1'b1;
                got_data_d = dmem_rdata;
            end
        end else begin
            we_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_valid && mem_is_load) begin
                        state_d   = WAIT_LD;
                        timer_d   = 8'd0;
                        got_d     = 1'b0;
                        ld_wd_d   = mem_wd;
                        ld_wreg_d = mem_wreg;
                    end else if (mem_valid) begin
                        we_d    = mem_wreg;
                        waddr_d = mem_wd;
                        wdata_d = mem_wdata;
                    end
                end
                WAIT_LD: begin
                    if (got_q || dmem_rvalid) begin
                        we_d    = ld_wreg_q;
                        waddr_d = ld_wd_q;
                        wdata_d = ld_data;
                        state_d = IDLE;
                        timer_d = 8'd0;
                        got_d   = 1'b0;
                    end else if (timer_q == TMO_LAST) begin
                        state_d = IDLE;
                        timer_d = 8'd0;
                        err_d   = 1'b1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= 8'd0;
            ld_wd_q    <= 5'd0;
            ld_wreg_q  <= 1'b0;
            got_q      <= 1'b0;
            got_data_q <= 32'd0;
            we_q       <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ld_wd_q    <= ld_wd_d;
            ld_wreg_q  <= ld_wreg_d;
            got_q      <= got_d;
            got_data_q <= got_data_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign stall_req_o = ((state_q == IDLE) && mem_valid && mem_is_load)
                       || ((state_q == WAIT_LD) && !dmem_rvalid && !got_q);
    assign wb_we    = we_q;
    assign wb_waddr = waddr_q;
    assign wb_wdata = wdata_q;
    assign ld_err_o = err_q;

endmodule
